// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder, STEP bits per clock, LSB chunk first.
// Optional add/subtract mode is enabled by defining SERIAL_ADDER_ADDSUB_EN.
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset
//   start  request an operation (sampled only while idle)
//   a, b   WIDTH-bit operands, captured on the accepting edge
//   cin    carry-in, captured on the accepting edge
//   busy   high while an operation is in progress
//   done   one-cycle pulse when sum/carry update
//   sum    last completed result
//   carry  carry-out of bit WIDTH-1 of the last completed result
//   sub    (SERIAL_ADDER_ADDSUB_EN) 1 = compute a - b
//   ovf    (SERIAL_ADDER_ADDSUB_EN) signed overflow of the last result

module serial_adder #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
`ifdef SERIAL_ADDER_ADDSUB_EN
    ,
    input  logic             sub,
    output logic             ovf
`endif
);

    localparam int N  = WIDTH / STEP;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE,
        ADD
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] op_a, op_b;
    logic [WIDTH-1:0] res, res_nxt;
    logic             run_c;
    logic [CW-1:0]    cnt;
    logic             last;
    int               base;

    logic [STEP-1:0]  a_chunk, b_chunk, slice_s;
    logic [STEP:0]    cv;
    logic             slice_c;

    assign last = (cnt == CW'(N - 1));
    assign busy = (state == ADD);
    assign base = int'(cnt) * STEP;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start) state_nxt = ADD;
            ADD:  if (last) state_nxt = IDLE;
        endcase
    end

    // Ripple slice over the current chunk, seeded by the running carry.
    always_comb begin
        a_chunk = op_a[base +: STEP];
        b_chunk = op_b[base +: STEP];
        cv      = '0;
        slice_s = '0;
        cv[0]   = run_c;
        for (int i = 0; i < STEP; i++) begin
            slice_s[i] = a_chunk[i] ^ b_chunk[i] ^ cv[i];
            cv[i+1]    = (a_chunk[i] & b_chunk[i])
                       | (cv[i] & (a_chunk[i] ^ b_chunk[i]));
        end
        slice_c = cv[STEP];
        res_nxt = res;
        res_nxt[base +: STEP] = slice_s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_a  <= '0;
            op_b  <= '0;
            res   <= '0;
            run_c <= 1'b0;
            cnt   <= '0;
            done  <= 1'b0;
            sum   <= '0;
            carry <= 1'b0;
`ifdef SERIAL_ADDER_ADDSUB_EN
            ovf   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        op_a <= a;
                        res  <= '0;
                        cnt  <= '0;
`ifdef SERIAL_ADDER_ADDSUB_EN
                        // Subtract as a + ~b + 1.
                        op_b  <= sub ? ~b : b;
                        run_c <= sub ? 1'b1 : cin;
`else
                        op_b  <= b;
                        run_c <= cin;
`endif
                    end
                end
                ADD: begin
                    res   <= res_nxt;
                    run_c <= slice_c;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        sum   <= res_nxt;
                        carry <= slice_c;
                        done  <= 1'b1;
`ifdef SERIAL_ADDER_ADDSUB_EN
                        // Like-signed operands giving an opposite-signed result.
                        ovf <= (op_a[WIDTH-1] == op_b[WIDTH-1])
                             && (res_nxt[WIDTH-1] != op_a[WIDTH-1]);
`endif
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: random and directed checks of serial_adder against an
// arithmetic reference, on three instances with STEP = 1, 4 and 8.

module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       cin = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;

    logic       busy_w  [3];
    logic       done_w  [3];
    logic       carry_w [3];
    logic [7:0] sum_w   [3];

`ifdef SERIAL_ADDER_ADDSUB_EN
    localparam bit HAS_SUB = 1'b1;
    logic sub = 1'b0;
    logic ovf_w [3];
    logic prev_ovf;
`else
    localparam bit HAS_SUB = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;

    logic [7:0] prev_sum;
    logic       prev_carry;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        serial_adder #(
            .WIDTH(8),
            .STEP((g == 0) ? 1 : ((g == 1) ? 4 : 8))
        ) dut (
            .clk(clk),
            .rst(rst),
            .start(start),
            .a(a),
            .b(b),
            .cin(cin),
            .busy(busy_w[g]),
            .done(done_w[g]),
            .sum(sum_w[g]),
            .carry(carry_w[g])
`ifdef SERIAL_ADDER_ADDSUB_EN
            ,
            .sub(sub),
            .ovf(ovf_w[g])
`endif
        );
    end

    function automatic int nc(input int d);
        return (d == 0) ? 8 : ((d == 1) ? 2 : 1);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_,
                          input logic tc, input logic ts);
        logic [8:0] r;
        logic       do_sub;
        int         sa, sb, sr;
        logic       eo;
        do_sub = ts & HAS_SUB;
        sa = int'($signed(ta));
        sb = int'($signed(tb_));
        if (do_sub) begin
            r  = {1'b0, ta} + {1'b0, ~tb_} + 9'd1;
            sr = sa - sb;
        end else begin
            r  = {1'b0, ta} + {1'b0, tb_} + {8'd0, tc};
            sr = sa + sb + int'(tc);
        end
        eo = (sr > 127) || (sr < -128);
        a = ta;
        b = tb_;
        cin = tc;
`ifdef SERIAL_ADDER_ADDSUB_EN
        sub = ts;
`endif
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        cin = 1'($urandom);
`ifdef SERIAL_ADDER_ADDSUB_EN
        sub = 1'($urandom);
`endif
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 3; d++) begin
                int n;
                n = nc(d);
                chk($sformatf("done d%0d c%0d", d, cyc), done_w[d], cyc == n);
                chk($sformatf("busy d%0d c%0d", d, cyc), busy_w[d], cyc < n);
                if (cyc < n) begin
                    chk($sformatf("hold_sum d%0d", d), sum_w[d], prev_sum);
                    chk($sformatf("hold_cy d%0d", d), carry_w[d], prev_carry);
                end else begin
                    chk($sformatf("sum d%0d %h_%h", d, ta, tb_), sum_w[d], r[7:0]);
                    chk($sformatf("carry d%0d %h_%h", d, ta, tb_), carry_w[d], r[8]);
`ifdef SERIAL_ADDER_ADDSUB_EN
                    chk($sformatf("ovf d%0d %h_%h", d, ta, tb_), ovf_w[d], eo);
`endif
                end
            end
        end
        prev_sum   = r[7:0];
        prev_carry = r[8];
`ifdef SERIAL_ADDER_ADDSUB_EN
        prev_ovf   = eo;
`endif
    endtask

    task automatic check_zero(input string tag);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s busy d%0d", tag, d), busy_w[d], 1'b0);
            chk($sformatf("%s done d%0d", tag, d), done_w[d], 1'b0);
            chk($sformatf("%s sum d%0d", tag, d), sum_w[d], 8'h00);
            chk($sformatf("%s carry d%0d", tag, d), carry_w[d], 1'b0);
`ifdef SERIAL_ADDER_ADDSUB_EN
            chk($sformatf("%s ovf d%0d", tag, d), ovf_w[d], 1'b0);
`endif
        end
    endtask

    initial begin
        prev_sum   = 8'h00;
        prev_carry = 1'b0;
`ifdef SERIAL_ADDER_ADDSUB_EN
        prev_ovf   = 1'b0;
`endif
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;

        run_op(8'hFF, 8'h01, 1'b0, 1'b0);
        run_op(8'hA5, 8'h5A, 1'b1, 1'b0);
        run_op(8'h12, 8'h34, 1'b0, 1'b0);
        run_op(8'h7F, 8'h01, 1'b0, 1'b0);
        run_op(8'h05, 8'h07, 1'b0, 1'b1);
        run_op(8'h80, 8'h01, 1'b1, 1'b1);

        // start held high; operands switched after accept.
        a = 8'h3C;
        b = 8'h21;
        cin = 1'b0;
`ifdef SERIAL_ADDER_ADDSUB_EN
        sub = 1'b0;
`endif
        start = 1'b1;
        @(posedge clk);
        #1;
        a = 8'h77;
        b = 8'h77;
        for (int cyc = 1; cyc <= 17; cyc++) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 3; d++) begin
                int n;
                n = nc(d);
                if (cyc % (n + 1) == n) begin
                    chk($sformatf("held done d%0d c%0d", d, cyc), done_w[d], 1'b1);
                    chk($sformatf("held sum d%0d c%0d", d, cyc), sum_w[d],
                        (cyc == n) ? 8'h5D : 8'hEE);
                    chk($sformatf("held carry d%0d c%0d", d, cyc), carry_w[d], 1'b0);
                    chk($sformatf("held busy d%0d c%0d", d, cyc), busy_w[d], 1'b0);
                end else begin
                    chk($sformatf("held done d%0d c%0d", d, cyc), done_w[d], 1'b0);
                    chk($sformatf("held busy d%0d c%0d", d, cyc), busy_w[d], 1'b1);
                end
            end
        end
        start = 1'b0;
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("held idle busy d%0d", d), busy_w[d], 1'b0);
            chk($sformatf("held idle done d%0d", d), done_w[d], 1'b0);
            chk($sformatf("held idle sum d%0d", d), sum_w[d], 8'hEE);
        end
        prev_sum   = 8'hEE;
        prev_carry = 1'b0;
`ifdef SERIAL_ADDER_ADDSUB_EN
        prev_ovf   = 1'b1;
`endif

        // Reset on the 4th ADD edge of FF+FF.
        a = 8'hFF;
        b = 8'hFF;
        cin = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_zero("abort");
        prev_sum   = 8'h00;
        prev_carry = 1'b0;
`ifdef SERIAL_ADDER_ADDSUB_EN
        prev_ovf   = 1'b0;
`endif
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("post_abort done d%0d", d), done_w[d], 1'b0);
                chk($sformatf("post_abort sum d%0d", d), sum_w[d], 8'h00);
            end
        end
        run_op(8'h12, 8'h34, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run_op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
